// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C slave exposing NUM_REGS 8-bit registers on regs_out.
// Define I2C_SLV_GLITCH_FILTER_EN to add a FILT_LEN-sample glitch filter on SCL/SDA.
//
// state  | meaning
// IDLE   | bus free, waiting for START
// ADDR   | shifting in 7-bit address + R/W, ACK decision at byte end
// ACK_A  | address ACK driven, next SCL fall picks PTR or RDATA
// PTR    | receiving register pointer byte and ACKing it
// WDATA  | receiving data bytes, writing registers on ACK
// RDATA  | shifting out registers, sampling master ACK/NACK
// IGNORE | not addressed or read finished, wait for START/STOP
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         NUM_REGS   = 4,
    parameter int         FILT_LEN   = 4
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        scl_oe,
    output logic                        sda_oe,
    output logic [8*NUM_REGS-1:0]       regs_out,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        busy
);
    localparam int PW = $clog2(NUM_REGS);

    if (NUM_REGS < 2 || NUM_REGS > 16 || (NUM_REGS & (NUM_REGS - 1)) != 0 || FILT_LEN < 1) begin : g_param_check
        $error("i2c_slave_regfile: illegal NUM_REGS or FILT_LEN");
    end

    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, PTR, WDATA, RDATA, IGNORE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      scl_sync, sda_sync;
    logic            scl_f, sda_f, scl_d, sda_d;
    logic            scl_rise, scl_fall, start_det, stop_det, addr_match;
    logic [7:0]      shreg;
    logic [3:0]      bit_cnt;
    logic [PW-1:0]   ptr;
    logic [7:0]      regs [NUM_REGS];

    // Idle-high reset values keep reset release from looking like bus activity.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] scl_cnt, sda_cnt;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_f) scl_cnt <= '0;
            else if (scl_cnt == FW'(FILT_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else scl_cnt <= scl_cnt + FW'(1);
            if (sda_sync[1] == sda_f) sda_cnt <= '0;
            else if (sda_cnt == FW'(FILT_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else sda_cnt <= sda_cnt + FW'(1);
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_d;
    assign scl_fall   = ~scl_f & scl_d;
    assign start_det  = sda_d & ~sda_f & scl_f & scl_d;
    assign stop_det   = ~sda_d & sda_f & scl_f & scl_d;
    assign addr_match = (shreg[7:1] == SLAVE_ADDR) && (shreg[7:1] != 7'd0);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det)     state_nxt = ADDR;
        else if (stop_det) state_nxt = IDLE;
        else begin
            case (state)
                ADDR:    if (scl_fall && bit_cnt == 4'd8) state_nxt = addr_match ? ACK_A : IGNORE;
                ACK_A:   if (scl_fall) state_nxt = shreg[0] ? RDATA : PTR;
                PTR:     if (scl_fall && bit_cnt == 4'd9) state_nxt = WDATA;
                RDATA:   if (scl_rise && bit_cnt == 4'd8 && sda_f) state_nxt = IGNORE;
                default: ;
            endcase
        end
    end

    // bit_cnt: 0..7 bits transferred, 8 = byte done, 9 = ACK slot in progress.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sda_oe   <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            ptr      <= '0;
            wr_pulse <= 1'b0;
            wr_index <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (start_det || stop_det) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd9;
                            if (state != ADDR || addr_match) sda_oe <= 1'b1;
                            if (state == PTR) ptr <= shreg[PW-1:0];
                            if (state == WDATA) begin
                                regs[ptr] <= shreg;
                                wr_pulse  <= 1'b1;
                                wr_index  <= ptr;
                                ptr       <= ptr + PW'(1);
                            end
                        end else if (scl_fall && bit_cnt == 4'd9) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    ACK_A: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (shreg[0]) begin
                                shreg  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                            end else sda_oe <= 1'b0;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
                            else if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd9;
                                if (!sda_f) ptr <= ptr + PW'(1);
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt < 4'd8) begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end else if (bit_cnt == 4'd8) sda_oe <= 1'b0;
                            else begin
                                shreg   <= regs[ptr];
                                sda_oe  <= ~regs[ptr][7];
                                bit_cnt <= '0;
                            end
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[8*k +: 8] = regs[k];
    end

    assign busy   = (state == ACK_A) || (state == PTR) || (state == WDATA) || (state == RDATA);
    assign scl_oe = 1'b0;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register-file reference model,
// and scoreboard queues checked by a monitor on wr_pulse and on received read bytes.
module tb_i2c_slave_regfile;
    localparam int         NR    = 4;
    localparam int         Q     = 10;
    localparam logic [6:0] SLAVE = 7'h55;
`ifdef I2C_SLV_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic            clk_clk = 1'b0;
    logic            reset_reset = 1'b1;
    logic            m_scl = 1'b1, m_sda = 1'b1, glitch = 1'b0;
    logic            scl_in, sda_in, scl_oe, sda_oe, wr_pulse, busy;
    logic [8*NR-1:0] regs_out;
    logic [1:0]      wr_index;

    assign scl_in = m_scl & ~scl_oe;
    assign sda_in = m_sda & ~sda_oe & ~glitch;

    always #10 clk_clk = ~clk_clk;

    i2c_slave_regfile #(.SLAVE_ADDR(SLAVE), .NUM_REGS(NR), .FILT_LEN(4)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .scl_in(scl_in), .sda_in(sda_in),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .regs_out(regs_out), .wr_pulse(wr_pulse),
        .wr_index(wr_index), .busy(busy)
    );

    typedef struct packed { logic [1:0] idx; logic [7:0] data; } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$], obs_rd[$];
    logic [7:0] model_regs[NR];
    int         model_ptr = 0;
    int         checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    wr_t  e;
    logic wr_pulse_q = 1'b0;
    always @(negedge clk_clk) begin
        if (wr_pulse) begin
            chk("wr_pulse_single", wr_pulse_q, 1'b0);
            if (exp_wr.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_index", wr_index, e.idx);
                chk("wr_data", regs_out[8*e.idx +: 8], e.data);
            end
        end
        wr_pulse_q = wr_pulse;
        while (obs_rd.size() > 0 && exp_rd.size() > 0)
            chk("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic bit_out(input logic b);
        wait_cyc(Q); m_sda = b; wait_cyc(Q); m_scl = 1'b1; wait_cyc(2*Q); m_scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        wait_cyc(Q); m_sda = 1'b1; wait_cyc(Q); m_scl = 1'b1; wait_cyc(Q); b = sda_in; wait_cyc(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_cyc(Q); m_sda = 1'b1; wait_cyc(Q); m_scl = 1'b1; wait_cyc(Q); m_sda = 1'b0; wait_cyc(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_cyc(Q); m_sda = 1'b0; wait_cyc(Q); m_scl = 1'b1; wait_cyc(Q); m_sda = 1'b1; wait_cyc(2*Q);
    endtask

    // gbit selects a bit (0 = MSB) that gets a 2-cycle SDA low glitch mid SCL-high.
    task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(Q); m_sda = b[7-i]; wait_cyc(Q); m_scl = 1'b1;
            if (i == gbit) begin
                wait_cyc(Q); glitch = 1'b1; wait_cyc(2); glitch = 1'b0; wait_cyc(Q-2);
            end else wait_cyc(2*Q);
            m_scl = 1'b0;
        end
        bit_in(s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        logic s;
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            bit_in(s);
            t = {t[6:0], s};
        end
        b = t;
        bit_out(~ack);
    endtask

    task automatic i2c_write(input logic [6:0] addr, input logic [7:0] ptr, input logic [31:0] data,
                             input int n, input int gbit);
        logic ack, alive;
        logic [7:0] b;
        alive = (addr == SLAVE);
        i2c_start();
        send_byte({addr, 1'b0}, -1, ack);
        chk("addr_ack", ack, alive);
        chk("busy_addr", busy, alive);
        send_byte(ptr, -1, ack);
        chk("ptr_ack", ack, alive);
        chk("busy_ptr", busy, alive);
        if (alive) model_ptr = int'(ptr) % NR;
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            if (i == 0 && gbit >= 0 && !FILT) alive = 1'b0;
            if (alive) begin
                model_regs[model_ptr] = b;
                exp_wr.push_back(wr_t'{idx: 2'(model_ptr), data: b});
                model_ptr = (model_ptr + 1) % NR;
            end
            send_byte(b, (i == 0) ? gbit : -1, ack);
            chk("data_ack", ack, alive);
            chk("busy_data", busy, alive);
        end
        i2c_stop();
        chk("busy_after_stop", busy, 1'b0);
    endtask

    task automatic i2c_read(input bit set_ptr, input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            send_byte({SLAVE, 1'b0}, -1, ack);
            chk("rd_waddr_ack", ack, 1'b1);
            send_byte(ptr, -1, ack);
            chk("rd_ptr_ack", ack, 1'b1);
            model_ptr = int'(ptr) % NR;
            i2c_start();
        end
        send_byte({SLAVE, 1'b1}, -1, ack);
        chk("rd_addr_ack", ack, 1'b1);
        chk("busy_read", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(model_regs[model_ptr]);
            recv_byte(b, i < n - 1);
            obs_rd.push_back(b);
            if (i < n - 1) model_ptr = (model_ptr + 1) % NR;
        end
        wait_cyc(Q);
        chk("sda_released_nack", sda_oe, 1'b0);
        chk("busy_after_nack", busy, 1'b0);
        i2c_stop();
        chk("busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        logic [6:0] ra;
        for (int k = 0; k < NR; k++) model_regs[k] = '0;
        wait_cyc(5);
        reset_reset = 1'b0;
        wait_cyc(2);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_scl_oe", scl_oe, 1'b0);
        chk("rst_regs", regs_out, '0);
        chk("rst_wr_pulse", wr_pulse, 1'b0);
        chk("rst_wr_index", wr_index, '0);
        chk("rst_busy", busy, 1'b0);

        i2c_write(SLAVE, 8'h01, 32'hA5, 1, -1);
        chk("regs_after_a5", regs_out, 32'h0000_A500);
        i2c_write(SLAVE, 8'h03, 32'h2211, 2, -1);
        chk("regs_after_wrap", regs_out, 32'h1100_A522);
        i2c_read(1'b1, 8'h00, 2);
        i2c_write(7'h54, 8'hFF, 32'hFF, 1, -1);
        i2c_write(7'h00, 8'h02, 32'h77, 1, -1);
        chk("regs_after_nack", regs_out, 32'h1100_A522);
        i2c_read(1'b0, 8'h00, 3);

        // Reset while the slave is driving a read bit low.
        i2c_write(SLAVE, 8'h00, 32'h3C, 1, -1);
        i2c_write(SLAVE, 8'hFC, 32'h0, 0, -1);
        i2c_start();
        send_byte({SLAVE, 1'b1}, -1, ack);
        chk("rst_rd_addr_ack", ack, 1'b1);
        wait_cyc(Q);
        chk("rdata_drives_low", sda_oe, 1'b1);
        reset_reset = 1'b1;
        wait_cyc(1);
        chk("midrst_sda_oe", sda_oe, 1'b0);
        chk("midrst_regs", regs_out, '0);
        chk("midrst_busy", busy, 1'b0);
        reset_reset = 1'b0;
        for (int k = 0; k < NR; k++) model_regs[k] = '0;
        model_ptr = 0;
        i2c_stop();
        i2c_write(SLAVE, 8'h02, 32'h5A, 1, -1);
        i2c_read(1'b1, 8'h02, 1);

        // SDA glitch during a '1' data bit while SCL is high.
        i2c_write(SLAVE, 8'h01, 32'hFF, 1, 2);
        i2c_read(1'b1, 8'h01, 1);

        for (int it = 0; it < 6; it++) begin
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE;
            i2c_write(ra, 8'($urandom_range(0, 255)), $urandom, $urandom_range(1, 3), -1);
            i2c_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        end

        wait_cyc(5);
        for (int k = 0; k < NR; k++) chk($sformatf("final_reg%0d", k), regs_out[8*k +: 8], model_regs[k]);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size() + obs_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
